bus_arbiter_zii: RTL and testbench



---
 rtl/bus_arbiter_zii.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_bus_arbiter_zii.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_zii.sv
// -----------------------------------------------------------------------------
// bus_arbiter_zii
//
// Bus arbitration and bootstrap for the accelerator card, clocked from C7M.
// After reset it works out which host board it sits on and takes the bus from
// the motherboard 68000. It then arbitrates between three masters: the local
// 68SEC000 (the default owner), NUM_DMA on-card DMA engines and motherboard
// DMA. Motherboard DMA uses the Zorro II BR/BG/BGACK handshake.
//
// Parameters
//   NUM_DMA        number of on-card DMA masters (1..4)
//   ROUND_ROBIN    0 = lowest index wins, 1 = rotate starting after last winner
//   TIMEOUT_CYCLES C7M cycles to wait for BGACK after a motherboard grant
//
// Optional feature macro
//   ARB_TIMEOUT_EN defined   : a motherboard grant that is not acknowledged
//                              within TIMEOUT_CYCLES is withdrawn, and
//                              ARB_TIMEOUT pulses for one cycle
//   ARB_TIMEOUT_EN undefined : XGNT waits for BGACK indefinitely and
//                              ARB_TIMEOUT is always 0
//
// Ports
//   C7M, RESET            clock and synchronous active-high reset
//   JP2                   E-clock jumper (1 forces takeover at bootstrap)
//   BOSS_n_IN, BG_n_IN,
//   BR_n_IN, BGACK_n_IN   motherboard arbitration lines as sampled
//   AS_n                  resolved address strobe (low = bus cycle active)
//   CPU_BG_n              bus grant from the local 68SEC000
//   DMA_REQ / DMA_GNT     local DMA level requests / one-hot grants
//   CPU_BR_n              bus request to the local 68SEC000
//   *_OUT / *_OE          motherboard line drive value and output enable
//   E_OE                  drive E clock onto the motherboard
//   DMA_ENABLED           motherboard DMA arbitration is active
//   ARB_TIMEOUT           one-cycle pulse when a motherboard grant times out
//
// Every output comes straight from a flop. No input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module bus_arbiter_zii #(
   parameter int NUM_DMA        = 2,
   parameter int ROUND_ROBIN    = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic               C7M,
   input  logic               RESET,
   input  logic               JP2,
   input  logic               BOSS_n_IN,
   input  logic               BG_n_IN,
   input  logic               BR_n_IN,
   input  logic               BGACK_n_IN,
   input  logic               AS_n,
   input  logic               CPU_BG_n,
   input  logic [NUM_DMA-1:0] DMA_REQ,
   output logic [NUM_DMA-1:0] DMA_GNT,
   output logic               CPU_BR_n,
   output logic               BR_n_OUT,
   output logic               BR_n_OE,
   output logic               BG_n_OUT,
   output logic               BG_n_OE,
   output logic               BOSS_n_OUT,
   output logic               BOSS_n_OE,
   output logic               BGACK_n_OUT,
   output logic               BGACK_n_OE,
   output logic               E_OE,
   output logic               DMA_ENABLED,
   output logic               ARB_TIMEOUT
);

   localparam int IDX_W = (NUM_DMA > 1) ? $clog2(NUM_DMA) : 1;

   // Reject out-of-range parameters at elaboration time
   if (NUM_DMA < 1 || NUM_DMA > 4) begin : g_bad_num_dma
      $error("bus_arbiter_zii: NUM_DMA must be in 1..4");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("bus_arbiter_zii: TIMEOUT_CYCLES must be in 1..255");
   end

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_HALT,
      ST_IDLE,
      ST_LREQ,
      ST_LOWN,
      ST_LREL,
      ST_XGNT,
      ST_XOWN
   } state_t;

   state_t             state_reg, state_next;
   logic               cpu_br_n_reg, cpu_br_n_next;
   logic [NUM_DMA-1:0] dma_gnt_reg, dma_gnt_next;
   logic               br_n_out_reg;
   logic               br_n_oe_reg, br_n_oe_next;
   logic               bg_n_out_reg, bg_n_out_next;
   logic               bg_n_oe_reg, bg_n_oe_next;
   logic               boss_n_out_reg, boss_n_out_next;
   logic               boss_n_oe_reg, boss_n_oe_next;
   logic               bgack_n_out_reg;
   logic               bgack_n_oe_reg;
   logic               e_oe_reg, e_oe_next;
   logic               dma_enabled_reg, dma_enabled_next;
   logic               arb_timeout_reg, arb_timeout_next;
   logic [IDX_W-1:0]   winner_reg, winner_next;
   logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] cnt_reg, cnt_next;
   // Set after a timeout. While it is set, the BR_n_IN low that timed out
   // cannot trigger a new grant. It clears once BR_n_IN is seen high.
   logic       br_block_reg, br_block_next;
`endif

   // ---------------------------------------------------------------------
   // Local DMA winner selection
   // In round-robin mode, first look only at channels at or above the
   // pointer. If none of those is requesting, fall back to the full request
   // vector. In both cases the lowest set index wins, so the search wraps.
   // ---------------------------------------------------------------------
   logic [NUM_DMA-1:0] above_ptr;
   logic [NUM_DMA-1:0] masked_req;
   logic [NUM_DMA-1:0] pick_vec;
   logic [IDX_W-1:0]   pick_idx;

   for (genvar gi = 0; gi < NUM_DMA; gi++) begin : g_mask
      assign above_ptr[gi] = (IDX_W'(gi) >= rr_ptr_reg);
   end

   assign masked_req = DMA_REQ & above_ptr;
   assign pick_vec   = ((ROUND_ROBIN != 0) && (|masked_req)) ? masked_req : DMA_REQ;

   always_comb begin
      pick_idx = '0;
      for (int k = NUM_DMA - 1; k >= 0; k--) begin
         if (pick_vec[k]) begin
            pick_idx = IDX_W'(k);
         end
      end
   end

   // A motherboard request is only taken when motherboard DMA is enabled
   logic mb_req;
`ifdef ARB_TIMEOUT_EN
   assign mb_req = dma_enabled_reg && !BR_n_IN && !br_block_reg;
`else
   assign mb_req = dma_enabled_reg && !BR_n_IN;
`endif

   // BG is currently being driven low onto the motherboard
   logic bg_granted;
   assign bg_granted = bg_n_oe_reg && !bg_n_out_reg;

   // ---------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next       = state_reg;
      cpu_br_n_next    = cpu_br_n_reg;
      dma_gnt_next     = dma_gnt_reg;
      br_n_oe_next     = br_n_oe_reg;
      bg_n_out_next    = bg_n_out_reg;
      bg_n_oe_next     = bg_n_oe_reg;
      boss_n_out_next  = boss_n_out_reg;
      boss_n_oe_next   = boss_n_oe_reg;
      e_oe_next        = e_oe_reg;
      dma_enabled_next = dma_enabled_reg;
      arb_timeout_next = 1'b0;
      winner_next      = winner_reg;
      rr_ptr_next      = rr_ptr_reg;
`ifdef ARB_TIMEOUT_EN
      cnt_next         = cnt_reg;
      br_block_next    = br_block_reg && !BR_n_IN;
`endif

      case (state_reg)
         ST_BOOT: begin
            if (BG_n_IN || JP2) begin
               cpu_br_n_next = 1'b1;
               e_oe_next     = !JP2;
               if (BOSS_n_IN) begin
                  // B2000: claim BOSS. Motherboard DMA goes through us.
                  boss_n_out_next  = 1'b0;
                  boss_n_oe_next   = 1'b1;
                  br_n_oe_next     = 1'b0;
                  dma_enabled_next = 1'b1;
               end else begin
                  // A500-style host. If the motherboard CPU still holds the
                  // bus (BG_n_IN low), keep requesting it forever.
                  br_n_oe_next     = !BG_n_IN;
                  dma_enabled_next = BG_n_IN;
               end
               state_next = ST_IDLE;
            end else begin
               state_next = ST_HALT;
            end
         end

         ST_HALT: begin
            // Only RESET leaves this state
            state_next = ST_HALT;
         end

         ST_IDLE: begin
            if (mb_req) begin
               cpu_br_n_next = 1'b0;
               state_next    = ST_XGNT;
            end else if (|DMA_REQ) begin
               winner_next   = pick_idx;
               cpu_br_n_next = 1'b0;
               state_next    = ST_LREQ;
            end
         end

         ST_LREQ: begin
            if (!CPU_BG_n && AS_n) begin
               dma_gnt_next             = '0;
               dma_gnt_next[winner_reg] = 1'b1;
               state_next               = ST_LOWN;
            end
         end

         ST_LOWN: begin
            if (!DMA_REQ[winner_reg]) begin
               dma_gnt_next = '0;
               state_next   = ST_LREL;
            end
         end

         ST_LREL: begin
            if (AS_n) begin
               cpu_br_n_next = 1'b1;
               rr_ptr_next   = (winner_reg == IDX_W'(NUM_DMA - 1)) ? '0 : winner_reg + 1'b1;
               state_next    = ST_IDLE;
            end
         end

         ST_XGNT: begin
            if (bg_granted && !BGACK_n_IN) begin
               bg_n_out_next = 1'b1;
               state_next    = ST_XOWN;
            end else if (BR_n_IN) begin
               // The requester gave up before acknowledging
               bg_n_out_next = 1'b1;
               bg_n_oe_next  = 1'b0;
               cpu_br_n_next = 1'b1;
               state_next    = ST_IDLE;
            end else if (!bg_granted) begin
               if (!CPU_BG_n && AS_n) begin
                  bg_n_oe_next  = 1'b1;
                  bg_n_out_next = 1'b0;
`ifdef ARB_TIMEOUT_EN
                  cnt_next      = 8'd0;
`endif
               end
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_reg == TIMEOUT_LAST) begin
               bg_n_out_next    = 1'b1;
               bg_n_oe_next     = 1'b0;
               cpu_br_n_next    = 1'b1;
               arb_timeout_next = 1'b1;
               br_block_next    = 1'b1;
               state_next       = ST_IDLE;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
`endif
         end

         ST_XOWN: begin
            if (BGACK_n_IN && BR_n_IN) begin
               bg_n_oe_next  = 1'b0;
               cpu_br_n_next = 1'b1;
               state_next    = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_BOOT;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge C7M) begin
      if (RESET) begin
         state_reg       <= ST_BOOT;
         cpu_br_n_reg    <= 1'b0;
         dma_gnt_reg     <= '0;
         br_n_out_reg    <= 1'b0;
         br_n_oe_reg     <= 1'b1;
         bg_n_out_reg    <= 1'b1;
         bg_n_oe_reg     <= 1'b0;
         boss_n_out_reg  <= 1'b1;
         boss_n_oe_reg   <= 1'b0;
         bgack_n_out_reg <= 1'b1;
         bgack_n_oe_reg  <= 1'b0;
         e_oe_reg        <= 1'b0;
         dma_enabled_reg <= 1'b0;
         arb_timeout_reg <= 1'b0;
         winner_reg      <= '0;
         rr_ptr_reg      <= '0;
`ifdef ARB_TIMEOUT_EN
         cnt_reg         <= 8'd0;
         br_block_reg    <= 1'b0;
`endif
      end else begin
         state_reg       <= state_next;
         cpu_br_n_reg    <= cpu_br_n_next;
         dma_gnt_reg     <= dma_gnt_next;
         br_n_oe_reg     <= br_n_oe_next;
         bg_n_out_reg    <= bg_n_out_next;
         bg_n_oe_reg     <= bg_n_oe_next;
         boss_n_out_reg  <= boss_n_out_next;
         boss_n_oe_reg   <= boss_n_oe_next;
         e_oe_reg        <= e_oe_next;
         dma_enabled_reg <= dma_enabled_next;
         arb_timeout_reg <= arb_timeout_next;
         winner_reg      <= winner_next;
         rr_ptr_reg      <= rr_ptr_next;
`ifdef ARB_TIMEOUT_EN
         cnt_reg         <= cnt_next;
         br_block_reg    <= br_block_next;
`endif
      end
   end

   assign DMA_GNT     = dma_gnt_reg;
   assign CPU_BR_n    = cpu_br_n_reg;
   assign BR_n_OUT    = br_n_out_reg;
   assign BR_n_OE     = br_n_oe_reg;
   assign BG_n_OUT    = bg_n_out_reg;
   assign BG_n_OE     = bg_n_oe_reg;
   assign BOSS_n_OUT  = boss_n_out_reg;
   assign BOSS_n_OE   = boss_n_oe_reg;
   assign BGACK_n_OUT = bgack_n_out_reg;
   assign BGACK_n_OE  = bgack_n_oe_reg;
   assign E_OE        = e_oe_reg;
   assign DMA_ENABLED = dma_enabled_reg;
   assign ARB_TIMEOUT = arb_timeout_reg;

endmodule

// File: tb/tb_bus_arbiter_zii.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_zii
//
// Directed testbench for bus_arbiter_zii. The DUT is built with NUM_DMA=2,
// ROUND_ROBIN=1 and TIMEOUT_CYCLES=4. Inputs change 1 ns after a rising edge,
// and outputs are checked at that same point, after the edge has settled.
// Output bundle bit order, MSB first:
//   CPU_BR_n, DMA_GNT[1:0], BR_n_OUT, BR_n_OE, BG_n_OUT, BG_n_OE,
//   BOSS_n_OUT, BOSS_n_OE, BGACK_n_OUT, BGACK_n_OE, E_OE, DMA_ENABLED,
//   ARB_TIMEOUT
// -----------------------------------------------------------------------------
module tb_bus_arbiter_zii;

   logic       C7M = 1'b0;
   logic       RESET;
   logic       JP2;
   logic       BOSS_n_IN;
   logic       BG_n_IN;
   logic       BR_n_IN;
   logic       BGACK_n_IN;
   logic       AS_n;
   logic       CPU_BG_n;
   logic [1:0] DMA_REQ;
   logic [1:0] DMA_GNT;
   logic       CPU_BR_n;
   logic       BR_n_OUT, BR_n_OE, BG_n_OUT, BG_n_OE;
   logic       BOSS_n_OUT, BOSS_n_OE, BGACK_n_OUT, BGACK_n_OE;
   logic       E_OE, DMA_ENABLED, ARB_TIMEOUT;

   int errors = 0;
   int checks = 0;

   // Expected output bundles: reset/HALT, B2000 boot, A500 boot
   localparam logic [13:0] RST_VEC   = 14'b0_00_01_10_10_10_000;
   localparam logic [13:0] B2000_VEC = 14'b1_00_00_10_01_10_110;
   localparam logic [13:0] A500_VEC  = 14'b1_00_01_10_10_10_000;

   logic [13:0] outs;
   assign outs = {CPU_BR_n, DMA_GNT, BR_n_OUT, BR_n_OE, BG_n_OUT, BG_n_OE,
                  BOSS_n_OUT, BOSS_n_OE, BGACK_n_OUT, BGACK_n_OE,
                  E_OE, DMA_ENABLED, ARB_TIMEOUT};

   // {CPU_BR_n, DMA_GNT}
   logic [2:0] loc;
   assign loc = {CPU_BR_n, DMA_GNT};

   // {BG_n_OUT, BG_n_OE, CPU_BR_n, ARB_TIMEOUT}
   logic [3:0] mb;
   assign mb = {BG_n_OUT, BG_n_OE, CPU_BR_n, ARB_TIMEOUT};

   always #5 C7M = ~C7M;

   bus_arbiter_zii #(
      .NUM_DMA        (2),
      .ROUND_ROBIN    (1),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .C7M         (C7M),
      .RESET       (RESET),
      .JP2         (JP2),
      .BOSS_n_IN   (BOSS_n_IN),
      .BG_n_IN     (BG_n_IN),
      .BR_n_IN     (BR_n_IN),
      .BGACK_n_IN  (BGACK_n_IN),
      .AS_n        (AS_n),
      .CPU_BG_n    (CPU_BG_n),
      .DMA_REQ     (DMA_REQ),
      .DMA_GNT     (DMA_GNT),
      .CPU_BR_n    (CPU_BR_n),
      .BR_n_OUT    (BR_n_OUT),
      .BR_n_OE     (BR_n_OE),
      .BG_n_OUT    (BG_n_OUT),
      .BG_n_OE     (BG_n_OE),
      .BOSS_n_OUT  (BOSS_n_OUT),
      .BOSS_n_OE   (BOSS_n_OE),
      .BGACK_n_OUT (BGACK_n_OUT),
      .BGACK_n_OE  (BGACK_n_OE),
      .E_OE        (E_OE),
      .DMA_ENABLED (DMA_ENABLED),
      .ARB_TIMEOUT (ARB_TIMEOUT)
   );

   task automatic tick();
      @(posedge C7M);
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      tick();
      tick();
      checks++;
      if (outs !== RST_VEC) begin
         errors++;
         $display("FAIL reset_values: got %b expected %b", outs, RST_VEC);
      end
      DMA_REQ  = 2'b11;
      CPU_BG_n = 1'b0;
      tick();
      checks++;
      if (outs !== RST_VEC) begin
         errors++;
         $display("FAIL reset_held: got %b expected %b", outs, RST_VEC);
      end
      DMA_REQ  = 2'b00;
      CPU_BG_n = 1'b1;
      $display("test_reset: done");
   endtask

   task automatic test_boot_a500();
      RESET = 1'b1; BG_n_IN = 1'b0; JP2 = 1'b1; BOSS_n_IN = 1'b0;
      tick();
      RESET = 1'b0;
      tick();
      checks++;
      if (outs !== A500_VEC) begin
         errors++;
         $display("FAIL boot_a500: got %b expected %b", outs, A500_VEC);
      end
      BR_n_IN = 1'b0; CPU_BG_n = 1'b0;
      repeat (4) tick();
      checks++;
      if ({CPU_BR_n, BG_n_OE, BG_n_OUT} !== 3'b101) begin
         errors++;
         $display("FAIL a500_br_ignored: got %b expected %b", {CPU_BR_n, BG_n_OE, BG_n_OUT}, 3'b101);
      end
      BR_n_IN = 1'b1; CPU_BG_n = 1'b1;
      $display("test_boot_a500: done");
   endtask

   task automatic test_halt();
      RESET = 1'b1; BG_n_IN = 1'b0; JP2 = 1'b0; BOSS_n_IN = 1'b1;
      tick();
      RESET = 1'b0;
      tick();
      checks++;
      if (outs !== RST_VEC) begin
         errors++;
         $display("FAIL halt_entry: got %b expected %b", outs, RST_VEC);
      end
      DMA_REQ = 2'b01; CPU_BG_n = 1'b0; BG_n_IN = 1'b1;
      repeat (4) tick();
      checks++;
      if (outs !== RST_VEC) begin
         errors++;
         $display("FAIL halt_hold: got %b expected %b", outs, RST_VEC);
      end
      DMA_REQ = 2'b00; CPU_BG_n = 1'b1;
      $display("test_halt: done");
   endtask

   task automatic test_boot_b2000();
      RESET = 1'b1; BG_n_IN = 1'b1; JP2 = 1'b0; BOSS_n_IN = 1'b1;
      tick();
      RESET = 1'b0;
      tick();
      checks++;
      if (outs !== B2000_VEC) begin
         errors++;
         $display("FAIL boot_b2000: got %b expected %b", outs, B2000_VEC);
      end
      $display("test_boot_b2000: done");
   endtask

   task automatic test_round_robin();
      AS_n = 1'b1; CPU_BG_n = 1'b1; DMA_REQ = 2'b11;
      tick();
      checks++;
      if (loc !== 3'b0_00) begin
         errors++;
         $display("FAIL rr_br_fall: got %b expected %b", loc, 3'b0_00);
      end
      tick(); tick();
      checks++;
      if (loc !== 3'b0_00) begin
         errors++;
         $display("FAIL rr_wait_bg: got %b expected %b", loc, 3'b0_00);
      end
      CPU_BG_n = 1'b0; AS_n = 1'b0;
      tick();
      checks++;
      if (loc !== 3'b0_00) begin
         errors++;
         $display("FAIL rr_wait_as: got %b expected %b", loc, 3'b0_00);
      end
      AS_n = 1'b1;
      tick();
      checks++;
      if (loc !== 3'b0_01) begin
         errors++;
         $display("FAIL rr_first_gnt: got %b expected %b", loc, 3'b0_01);
      end
      DMA_REQ = 2'b10;
      tick();
      checks++;
      if (loc !== 3'b0_00) begin
         errors++;
         $display("FAIL rr_drop_gnt: got %b expected %b", loc, 3'b0_00);
      end
      AS_n = 1'b0;
      tick();
      checks++;
      if (loc !== 3'b0_00) begin
         errors++;
         $display("FAIL rr_rel_wait_as: got %b expected %b", loc, 3'b0_00);
      end
      AS_n = 1'b1;
      tick();
      checks++;
      if (loc !== 3'b1_00) begin
         errors++;
         $display("FAIL rr_release: got %b expected %b", loc, 3'b1_00);
      end
      DMA_REQ = 2'b11;
      tick(); tick();
      checks++;
      if (loc !== 3'b0_10) begin
         errors++;
         $display("FAIL rr_second_gnt: got %b expected %b", loc, 3'b0_10);
      end
      DMA_REQ = 2'b01;
      tick(); tick();
      checks++;
      if (loc !== 3'b1_00) begin
         errors++;
         $display("FAIL rr_release2: got %b expected %b", loc, 3'b1_00);
      end
      DMA_REQ = 2'b11;
      tick(); tick();
      checks++;
      if (loc !== 3'b0_01) begin
         errors++;
         $display("FAIL rr_third_gnt: got %b expected %b", loc, 3'b0_01);
      end
      DMA_REQ = 2'b00;
      tick(); tick();
      $display("test_round_robin: done");
   endtask

   task automatic test_simultaneous();
      BR_n_IN = 1'b0; DMA_REQ = 2'b01; CPU_BG_n = 1'b0; AS_n = 1'b1; BGACK_n_IN = 1'b1;
      tick();
      checks++;
      if ({loc, BG_n_OUT, BG_n_OE} !== 5'b0_00_1_0) begin
         errors++;
         $display("FAIL sim_xgnt: got %b expected %b", {loc, BG_n_OUT, BG_n_OE}, 5'b0_00_1_0);
      end
      tick();
      checks++;
      if ({loc, BG_n_OUT, BG_n_OE} !== 5'b0_00_0_1) begin
         errors++;
         $display("FAIL sim_bg_assert: got %b expected %b", {loc, BG_n_OUT, BG_n_OE}, 5'b0_00_0_1);
      end
      BGACK_n_IN = 1'b0;
      tick();
      checks++;
      if ({loc, BG_n_OUT, BG_n_OE} !== 5'b0_00_1_1) begin
         errors++;
         $display("FAIL sim_xown: got %b expected %b", {loc, BG_n_OUT, BG_n_OE}, 5'b0_00_1_1);
      end
      BR_n_IN = 1'b1;
      repeat (3) tick();
      checks++;
      if ({loc, BG_n_OUT, BG_n_OE} !== 5'b0_00_1_1) begin
         errors++;
         $display("FAIL sim_xown_hold: got %b expected %b", {loc, BG_n_OUT, BG_n_OE}, 5'b0_00_1_1);
      end
      BGACK_n_IN = 1'b1;
      tick();
      checks++;
      if ({loc, BG_n_OUT, BG_n_OE} !== 5'b1_00_1_0) begin
         errors++;
         $display("FAIL sim_xown_exit: got %b expected %b", {loc, BG_n_OUT, BG_n_OE}, 5'b1_00_1_0);
      end
      tick(); tick();
      checks++;
      if (loc !== 3'b0_01) begin
         errors++;
         $display("FAIL sim_local_after: got %b expected %b", loc, 3'b0_01);
      end
      DMA_REQ = 2'b00;
      tick(); tick();
      $display("test_simultaneous: done");
   endtask

   task automatic test_timeout();
      BR_n_IN = 1'b0; CPU_BG_n = 1'b0; AS_n = 1'b1; BGACK_n_IN = 1'b1; DMA_REQ = 2'b00;
      tick(); tick();
      checks++;
      if (mb !== 4'b0_1_0_0) begin
         errors++;
         $display("FAIL to_grant: got %b expected %b", mb, 4'b0_1_0_0);
      end
`ifdef ARB_TIMEOUT_EN
      repeat (3) tick();
      checks++;
      if (mb !== 4'b0_1_0_0) begin
         errors++;
         $display("FAIL to_before_expiry: got %b expected %b", mb, 4'b0_1_0_0);
      end
      tick();
      checks++;
      if (mb !== 4'b1_0_1_1) begin
         errors++;
         $display("FAIL to_expiry: got %b expected %b", mb, 4'b1_0_1_1);
      end
      tick(); tick();
      checks++;
      if (mb !== 4'b1_0_1_0) begin
         errors++;
         $display("FAIL to_blocked: got %b expected %b", mb, 4'b1_0_1_0);
      end
      BR_n_IN = 1'b1;
      tick();
      BR_n_IN = 1'b0;
      tick();
      checks++;
      if ({CPU_BR_n, BG_n_OE} !== 2'b00) begin
         errors++;
         $display("FAIL to_reenter: got %b expected %b", {CPU_BR_n, BG_n_OE}, 2'b00);
      end
      tick();
`else
      repeat (8) tick();
      checks++;
      if (mb !== 4'b0_1_0_0) begin
         errors++;
         $display("FAIL to_wait_forever: got %b expected %b", mb, 4'b0_1_0_0);
      end
`endif
      BR_n_IN = 1'b1;
      tick();
      checks++;
      if (mb !== 4'b1_0_1_0) begin
         errors++;
         $display("FAIL to_withdraw: got %b expected %b", mb, 4'b1_0_1_0);
      end
      $display("test_timeout: done");
   endtask

   task automatic test_reset_in_lown();
      BR_n_IN = 1'b1; DMA_REQ = 2'b01; CPU_BG_n = 1'b0; AS_n = 1'b1;
      tick(); tick();
      checks++;
      if (loc !== 3'b0_01) begin
         errors++;
         $display("FAIL lown_gnt: got %b expected %b", loc, 3'b0_01);
      end
      RESET = 1'b1;
      tick();
      checks++;
      if (outs !== RST_VEC) begin
         errors++;
         $display("FAIL lown_reset: got %b expected %b", outs, RST_VEC);
      end
      RESET = 1'b0;
      tick();
      checks++;
      if (outs !== B2000_VEC) begin
         errors++;
         $display("FAIL lown_reboot: got %b expected %b", outs, B2000_VEC);
      end
      tick(); tick();
      checks++;
      if (loc !== 3'b0_01) begin
         errors++;
         $display("FAIL lown_regrant: got %b expected %b", loc, 3'b0_01);
      end
      DMA_REQ = 2'b00;
      tick(); tick();
      $display("test_reset_in_lown: done");
   endtask

   initial begin
      RESET      = 1'b1;
      JP2        = 1'b0;
      BOSS_n_IN  = 1'b1;
      BG_n_IN    = 1'b1;
      BR_n_IN    = 1'b1;
      BGACK_n_IN = 1'b1;
      AS_n       = 1'b1;
      CPU_BG_n   = 1'b1;
      DMA_REQ    = 2'b00;

      test_reset();
      test_boot_a500();
      test_halt();
      test_boot_b2000();
      test_round_robin();
      test_simultaneous();
      test_timeout();
      test_reset_in_lown();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
